// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : M-extension op codes and FSM state type shared by muldiv_seq
// Revision   : 1.0
// ============================================================================
package muldiv_pkg;

  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
// muldiv_div_step : one restoring-division step (shift in a bit, trial subtract)
// Revision        : 1.0
// ============================================================================
module muldiv_div_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic            qbit_o
);

  logic [XLEN:0] w_trial;
  logic [XLEN:0] w_diff;

  // rem_i < div_i holds on entry, so the trial value is below 2*div and the
  // restored or reduced remainder always fits back into XLEN bits.
  assign w_trial = {rem_i, bit_i};
  assign w_diff  = w_trial - {1'b0, div_i};
  assign qbit_o  = ~w_diff[XLEN];
  assign rem_o   = qbit_o ? w_diff[XLEN-1:0] : w_trial[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// muldiv_seq : sequential RV32M multiply/divide unit; MULDIV_FAST_MUL_EN
//              selects a single-cycle combinational multiply
// Revision   : 1.0
// ============================================================================
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [4:0]      OP,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] Y,
  input  logic            FLUSH,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] RESULT
);

  localparam int              CW         = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [CW-1:0]   C_CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] C_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            setup_q, byp_q, neg_q, rneg_q, in_ready_q, out_valid_q;
  logic [4:0]      op_q;
  logic [XLEN-1:0] x_q, y_q, hi_q, lo_q, mc_q, res_q;

  logic w_is_mul, w_is_div, w_x_neg, w_y_neg, w_want_rem, w_want_low;
  logic w_x_signed, w_y_signed, w_div_zero, w_div_ovf, w_qbit, w_byp;
  logic [XLEN-1:0]   w_x_mag, w_y_mag, w_rem_nxt, w_quo_nxt, w_byp_res;
  logic [XLEN-1:0]   w_div_res, w_mul_res;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_prod_nxt, w_prod_fix;

  assign w_is_mul   = (op_q >= OP_MUL) && (op_q <= OP_MULHU);
  assign w_is_div   = (op_q >= OP_DIV) && (op_q <= OP_REMU);
  assign w_x_signed = (op_q == OP_MULH) || (op_q == OP_MULHSU) ||
                      (op_q == OP_DIV)  || (op_q == OP_REM);
  assign w_y_signed = (op_q == OP_MULH) || (op_q == OP_DIV) || (op_q == OP_REM);
  assign w_want_rem = (op_q == OP_REM) || (op_q == OP_REMU);
  assign w_want_low = (op_q == OP_MUL);
  assign w_x_neg    = w_x_signed & x_q[XLEN-1];
  assign w_y_neg    = w_y_signed & y_q[XLEN-1];
  assign w_x_mag    = w_x_neg ? -x_q : x_q;
  assign w_y_mag    = w_y_neg ? -y_q : y_q;
  assign w_div_zero = (y_q == '0);
  assign w_div_ovf  = w_x_signed && w_y_signed && (x_q == C_INT_MIN) && (y_q == '1);

  muldiv_div_step #(.XLEN(XLEN)) u_step (
    .rem_i  (hi_q),
    .bit_i  (lo_q[XLEN-1]),
    .div_i  (mc_q),
    .rem_o  (w_rem_nxt),
    .qbit_o (w_qbit)
  );

  assign w_quo_nxt = {lo_q[XLEN-2:0], w_qbit};
  assign w_div_res = w_want_rem ? (rneg_q ? -w_rem_nxt : w_rem_nxt)
                                : (neg_q  ? -w_quo_nxt : w_quo_nxt);

  // Shift-add: hi_q accumulates, lo_q holds the multiplier and shifts right.
  assign w_sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mc_q} : '0);
  assign w_prod_nxt = {w_sum, lo_q[XLEN-1:1]};
  assign w_prod_fix = neg_q ? -w_prod_nxt : w_prod_nxt;
  assign w_mul_res  = w_want_low ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_xe, w_ye, w_fast;
  assign w_xe   = {{XLEN{w_x_neg}}, x_q};
  assign w_ye   = {{XLEN{w_y_neg}}, y_q};
  assign w_fast = w_xe * w_ye;
`endif

  always_comb begin
    w_byp     = 1'b0;
    w_byp_res = '0;
    if (!w_is_mul && !w_is_div) begin
      w_byp = 1'b1;
    end else if (w_is_div && (w_div_zero || w_div_ovf)) begin
      w_byp = 1'b1;
      if (w_div_zero) w_byp_res = w_want_rem ? x_q : '1;
      else            w_byp_res = w_want_rem ? '0  : x_q;
`ifdef MULDIV_FAST_MUL_EN
    end else if (w_is_mul) begin
      w_byp     = 1'b1;
      w_byp_res = w_want_low ? w_fast[XLEN-1:0] : w_fast[2*XLEN-1:XLEN];
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      setup_q     <= 1'b0;
      byp_q       <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      op_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      mc_q        <= '0;
      res_q       <= '0;
    end else if (FLUSH) begin
      state_q     <= IDLE;
      setup_q     <= 1'b0;
      byp_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (IN_VALID && in_ready_q) begin
            op_q       <= OP;
            x_q        <= X;
            y_q        <= Y;
            cnt_q      <= C_CNT_LAST;
            setup_q    <= 1'b1;
            byp_q      <= 1'b0;
            in_ready_q <= 1'b0;
            state_q    <= ((OP >= OP_DIV) && (OP <= OP_REMU)) ? DIV : MUL;
          end
        end
        MUL, DIV: begin
          // First cycle after accept: prepare magnitudes or park a bypass result.
          if (setup_q) begin
            setup_q <= 1'b0;
            byp_q   <= w_byp;
            hi_q    <= w_byp ? w_byp_res : '0;
            lo_q    <= (state_q == DIV) ? w_x_mag : w_y_mag;
            mc_q    <= (state_q == DIV) ? w_y_mag : w_x_mag;
            neg_q   <= w_x_neg ^ w_y_neg;
            rneg_q  <= w_x_neg;
          end else if (byp_q) begin
            res_q       <= hi_q;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            if (state_q == DIV) begin
              hi_q <= w_rem_nxt;
              lo_q <= w_quo_nxt;
            end else begin
              {hi_q, lo_q} <= w_prod_nxt;
            end
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) begin
              res_q       <= (state_q == DIV) ? w_div_res : w_mul_res;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (OUT_READY) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign RESULT    = res_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// tb_muldiv_seq : directed + randomized scoreboard bench for muldiv_seq
// Revision      : 1.0
// ============================================================================
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic [4:0]  op;
  logic [31:0] x, y;
  logic        in_ready, out_valid;
  logic [31:0] result;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  muldiv_seq #(.XLEN(32)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .OP        (op),
    .X         (x),
    .Y         (y),
    .FLUSH     (flush),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .RESULT    (result)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      5'd10: begin p = 64'(ua * ub); return p[31:0];  end
      5'd11: begin p = 64'(sa * sb); return p[63:32]; end
      5'd12: begin p = 64'(sa * ub); return p[63:32]; end
      5'd13: begin p = 64'(ua * ub); return p[63:32]; end
      5'd14: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      5'd16: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
      5'd17: return (b == 0) ? a : 32'(ua % ub);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [4:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
    if (o < 5'd10 || o > 5'd17) return 2;
    if (o >= 5'd14)
      return ((b == 0) || ((o == 5'd14 || o == 5'd16) &&
              a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 2 : 33;
`ifdef MULDIV_FAST_MUL_EN
    return 2;
`else
    return 33;
`endif
  endfunction

  task automatic start_op(input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    op = o; x = a; y = b; in_valid = 1'b1;
    exp_q.push_back(e);
    lat_q.push_back(exp_lat(o, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int          lat = 0;
    logic [31:0] e;
    int          l;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      check({tag, "_result"}, result, e);
      check({tag, "_latency"}, lat, l);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_consumed_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_consumed_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [4:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] e);
    start_op(o, a, b, e);
    wait_result(tag);
    consume(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held, dummy;
    logic        seen;
    logic [4:0]  ro;
    logic [31:0] rx, ry;

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    op = '0; x = '0; y = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    run("div_neg",   5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem_neg",   5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("divu_zero", 5'd15, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("remu_zero", 5'd17, 32'd5, 32'd0, 32'd5);
    run("div_ovf",   5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf",   5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run("mul_min",   5'd10, 32'h8000_0000, 32'h8000_0000, 32'd0);
    run("mulh_min",  5'd11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mulhsu_m1", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mulhu_m1",  5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("bad_op_3",  5'd3,  32'd123, 32'd7, 32'd0);
    run("bad_op_20", 5'd20, 32'hDEAD_BEEF, 32'd1, 32'd0);

    for (int i = 0; i < 8; i++) begin
      ro = 5'(10 + $urandom_range(0, 7));
      rx = $urandom;
      ry = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 9));
      run("random", ro, rx, ry, model(ro, rx, ry));
    end

    // Back-pressure in DONE
    start_op(5'd15, 32'd1000, 32'd7, 32'd142);
    wait_result("bp");
    held = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_result_stable", result, held);
      check("bp_valid_held", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    consume("bp");

    // FLUSH in the 10th DIV cycle
    start_op(5'd15, 32'hFFFF_0000, 32'd3, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    dummy = exp_q.pop_back();
    void'(lat_q.pop_back());
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_no_valid", {31'd0, seen}, 32'd0);

    // FLUSH in IDLE blocks accept
    in_valid = 1'b1; flush = 1'b1; op = 5'd14; x = 32'd9; y = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle_blocks", {31'd0, in_ready}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("flush_idle_no_valid", {31'd0, out_valid}, 32'd0);

    // FLUSH together with OUT_READY in DONE
    start_op(5'd14, 32'd100, 32'd7, 32'd14);
    wait_result("flush_rdy");
    flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    check("flush_rdy_valid", {31'd0, out_valid}, 32'd0);
    check("flush_rdy_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a division
    start_op(5'd14, 32'hFFFF_FF00, 32'd5, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dummy = exp_q.pop_back();
    void'(lat_q.pop_back());
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);

    run("post_reset", 5'd16, 32'd100, 32'hFFFF_FFF9, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; compute-cycle count equals XLEN.
REQ-002 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port RST_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port IN_VALID  input  1  request present.
REQ-005 SHALL have port IN_READY  output  1  unit can accept a request.
REQ-006 SHALL have port OP  input  5  operation code, M-extension encoding 10..17 (mul, mulh, mulhsu, mulhu, div, divu, rem, remu).
REQ-007 SHALL have port X  input  XLEN  operand 1 (dividend / multiplicand).
REQ-008 SHALL have port Y  input  XLEN  operand 2 (divisor / multiplier).
REQ-009 SHALL have port FLUSH  input  1  abort in-flight operation.
REQ-010 SHALL have port OUT_VALID  output  1  RESULT valid.
REQ-011 SHALL have port OUT_READY  input  1  consumer takes RESULT.
REQ-012 SHALL have port RESULT  output  XLEN  registered result.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-014 SHALL drive IN_READY = 1 only in IDLE; accept occurs on an edge with IN_VALID & IN_READY; X, Y, OP captured at accept.
REQ-015 On accept, SHALL go to DIV for OP 14..17 or MUL for OP 10..13, loading iteration counter to XLEN-1.
REQ-016 DIV SHALL perform one restoring-division step per cycle on operand magnitudes (signed ops) or raw values (unsigned), leaving DIV after the counter-0 step; OUT_VALID SHALL rise XLEN+1 edges after the accept edge.
REQ-017 Signed fix-up: quotient negated when operand signs differ; remainder takes dividend sign.
REQ-018 Divide by zero SHALL bypass iteration: quotient all-ones, remainder = X; OUT_VALID 2 edges after accept.
REQ-019 Signed overflow (X = 0x80000000, Y = all-ones, OP 14/16) SHALL bypass iteration: quotient = X, remainder = 0; OUT_VALID 2 edges after accept.
REQ-020 MUL SHALL form the full 2*XLEN product (signed*signed, signed*unsigned, unsigned*unsigned per OP); OP 10 returns low half, OP 11..13 return high half.
REQ-021 OP outside 10..17 SHALL still be accepted and complete with RESULT = 0, OUT_VALID 2 edges after accept.
REQ-022 DONE SHALL hold OUT_VALID = 1 and RESULT stable until an edge with OUT_READY = 1, then go to IDLE; no new accept in that same edge.
REQ-023 FLUSH = 1 in any state SHALL return FSM to IDLE on the next edge, OUT_VALID = 0, no result delivered; FLUSH in IDLE with IN_VALID SHALL block the accept.
REQ-024 Overlapping FLUSH and OUT_READY in DONE SHALL both resolve to IDLE (result counted consumed).

Reset
REQ-025 RST_N = 0 at an edge SHALL force IDLE, OUT_VALID = 0, RESULT = 0, counter = 0, from any state including mid-DIV/MUL; IN_READY = 1 in the first cycle after release.
REQ-026 Reset SHALL take priority over FLUSH and handshakes.

Configuration
REQ-027 With MULDIV_FAST_MUL_EN defined, MUL SHALL compute the product combinationally in one cycle; OUT_VALID 2 edges after accept.
REQ-028 Without MULDIV_FAST_MUL_EN, MUL SHALL use a shift-add iteration of one multiplier bit per cycle; OUT_VALID XLEN+1 edges after accept; results identical.

Structure
REQ-029 Shared package muldiv_pkg SHALL hold the OP code constants (OP_MUL=10 .. OP_REMU=17) and the FSM state typedef.
REQ-030 Restoring-division step (partial remainder, divisor -> next remainder, quotient bit) SHALL be sub-module muldiv_div_step; everything else stays in muldiv_seq.

Verification
REQ-031 OP 14, X = 0xFFFFFFF9, Y = 2 -> RESULT 0xFFFFFFFD, OUT_VALID 33 edges after accept; OP 16 same operands -> 0xFFFFFFFF.
REQ-032 OP 15, X = 5, Y = 0 -> 0xFFFFFFFF; OP 17 -> 5; both 2 edges after accept.
REQ-033 OP 14, X = 0x80000000, Y = 0xFFFFFFFF -> 0x80000000; OP 16 -> 0.
REQ-034 X = Y = 0x80000000: OP 10 -> 0, OP 11 -> 0x40000000; X = Y = 0xFFFFFFFF: OP 12 -> 0xFFFFFFFF, OP 13 -> 0xFFFFFFFE; run with and without MULDIV_FAST_MUL_EN, checking 2 vs 33 edge latency.
REQ-035 OUT_READY held 0 for 5 cycles in DONE -> RESULT stable, IN_READY 0; then OUT_READY 1 -> IDLE next edge.
REQ-036 FLUSH at 10th DIV cycle -> IDLE next edge, OUT_VALID never rises; RST_N low mid-DIV -> all outputs at reset values next cycle.
